// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default constants for the fetch controller
// Ports: none (package).
package fetch_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_REQ    = 2'd1;
    localparam logic [1:0] STATE_SQUASH = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = STATE_IDLE,
        REQ    = STATE_REQ,
        SQUASH = STATE_SQUASH
    } fetch_state_t;

    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory request/ready bus between fetch controller and memory
// Signals: mem_req/mem_addr (controller -> memory), mem_ready/mem_rdata (memory -> controller).
// Modports: master (fetch controller), slave (instruction memory).
interface fetch_if #(
    parameter int BIT_NUMBER = 32
);
    logic                  mem_req;
    logic [BIT_NUMBER-1:0] mem_addr;
    logic                  mem_ready;
    logic [BIT_NUMBER-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_out_reg.sv
// rtl/fetch_out_reg.sv - one-entry holding register for a fetched instruction and its PC+step
// Ports: clk, rst (async active-low), load/clear controls, load_pc/load_instruction data in,
//        valid/pc/instruction registered outputs. Load wins over clear; otherwise contents hold.
module fetch_out_reg #(
    parameter int BIT_NUMBER = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [BIT_NUMBER-1:0] load_pc,
    input  logic [BIT_NUMBER-1:0] load_instruction,
    output logic                  valid,
    output logic [BIT_NUMBER-1:0] pc,
    output logic [BIT_NUMBER-1:0] instruction
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= 1'b0;
            pc          <= '0;
            instruction <= '0;
        end else if (load) begin
            valid       <= 1'b1;
            pc          <= load_pc;
            instruction <= load_instruction;
        end else if (clear) begin
            // Only the valid flag drops; stale data is harmless once invalid.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - IF-stage fetch sequencer with hazard stall, branch redirect and squash
// Ports: clk, rst (async active-low), hazard_stall, branch_taken, branch_address,
//        mem (fetch_if.master: mem_req/mem_addr out, mem_ready/mem_rdata in),
//        if_valid/if_pc/if_instruction (output register contents).
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                    BIT_NUMBER = 32,
    parameter int unsigned           PC_STEP    = DEFAULT_PC_STEP,
    parameter logic [BIT_NUMBER-1:0] RESET_PC   = BIT_NUMBER'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hazard_stall,
    input  logic                  branch_taken,
    input  logic [BIT_NUMBER-1:0] branch_address,
    fetch_if.master               mem,
    output logic                  if_valid,
    output logic [BIT_NUMBER-1:0] if_pc,
    output logic [BIT_NUMBER-1:0] if_instruction
);

    localparam logic [BIT_NUMBER-1:0] STEP = BIT_NUMBER'(PC_STEP);

    fetch_state_t          state;
    logic [BIT_NUMBER-1:0] fetch_pc;
    logic [BIT_NUMBER-1:0] req_addr;
    logic                  req;

    logic                  completion;
    logic                  consume;
    logic                  slot_free;
    logic                  load_out;
    logic                  clear_out;
    logic [BIT_NUMBER-1:0] next_pc;

    assign completion = req && mem.mem_ready;
    assign consume    = if_valid && !hazard_stall;
    assign slot_free  = !if_valid || !hazard_stall;
    assign next_pc    = fetch_pc + STEP;  // wraps modulo 2^BIT_NUMBER

    // Data from a squashed request, or one racing a branch, is never loaded.
    assign load_out  = (state == REQ) && completion && !branch_taken;
    assign clear_out = branch_taken || consume;

    assign mem.mem_req  = req;
    assign mem.mem_addr = req_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req      <= 1'b0;
            req_addr <= RESET_PC;
        end else begin
            if (branch_taken) begin
                fetch_pc <= branch_address;
            end else if (load_out) begin
                fetch_pc <= next_pc;
            end

            case (state)
                IDLE: begin
                    // Issue only into a slot that is empty or being drained this
                    // cycle, so a completion can never overwrite a live entry.
                    if (slot_free && !branch_taken) begin
                        state    <= REQ;
                        req      <= 1'b1;
                        req_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (completion) begin
                        state <= IDLE;
                        req   <= 1'b0;
                    end else if (branch_taken) begin
                        // The request cannot be withdrawn; let it finish and drop it.
                        state <= SQUASH;
                    end
                end
                SQUASH: begin
                    if (completion) begin
                        state <= IDLE;
                        req   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    fetch_out_reg #(
        .BIT_NUMBER(BIT_NUMBER)
    ) u_out_reg (
        .clk              (clk),
        .rst              (rst),
        .load             (load_out),
        .clear            (clear_out),
        .load_pc          (next_pc),
        .load_instruction (mem.mem_rdata),
        .valid            (if_valid),
        .pc               (if_pc),
        .instruction      (if_instruction)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized self-checking bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_stall;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    fetch_if #(.BIT_NUMBER(32)) mem_bus ();

    fetch_controller #(
        .BIT_NUMBER (32),
        .PC_STEP    (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_stall   (hazard_stall),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .mem            (mem_bus),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an outstanding-request record plus the output slot.
    bit          m_busy;
    logic [31:0] m_addr;
    bit          m_drop;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    int          lat_left;

    int hz_pct, br_pct, lat_min, lat_max;
    bit saw_wrap_pc, saw_wrap_addr;

    task automatic model_reset();
        m_busy   = 0;
        m_addr   = 32'h0;
        m_drop   = 0;
        m_pc     = 32'h0;
        m_valid  = 0;
        m_ipc    = 32'h0;
        m_instr  = 32'h0;
        lat_left = -1;
    endtask

    task automatic set_knobs(input int hz, input int br, input int lmin, input int lmax);
        hz_pct  = hz;
        br_pct  = br;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    task automatic drive_inputs(input bit force_br, input logic [31:0] force_addr);
        hazard_stall   = (int'($urandom_range(99)) < hz_pct);
        branch_taken   = (int'($urandom_range(99)) < br_pct);
        branch_address = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        if (force_br) begin
            branch_taken   = 1'b1;
            branch_address = force_addr;
        end
        mem_bus.mem_rdata = $urandom;
        if (m_busy) begin
            if (lat_left < 0) lat_left = int'($urandom_range(lat_max, lat_min));
            mem_bus.mem_ready = (lat_left == 0);
            if (lat_left > 0) lat_left--;
        end else begin
            mem_bus.mem_ready = $urandom_range(1);
        end
    endtask

    task automatic model_update();
        bit done, consume, free;
        done    = m_busy && mem_bus.mem_ready;
        consume = m_valid && !hazard_stall;
        free    = !m_valid || !hazard_stall;
        if (branch_taken) begin
            m_pc    = branch_address;
            m_valid = 0;
            if (done) begin
                m_busy = 0;
                m_drop = 0;
            end else if (m_busy) begin
                m_drop = 1;
            end
        end else if (m_busy) begin
            if (consume) m_valid = 0;
            if (done) begin
                if (!m_drop) begin
                    m_valid = 1;
                    m_instr = mem_bus.mem_rdata;
                    m_ipc   = m_addr + 32'd4;
                    m_pc    = m_addr + 32'd4;
                end
                m_busy = 0;
                m_drop = 0;
            end
        end else begin
            if (consume) m_valid = 0;
            if (free) begin
                m_busy = 1;
                m_addr = m_pc;
                m_drop = 0;
            end
        end
        if (done) lat_left = -1;
    endtask

    task automatic check_outputs();
        check("mem_req", {31'b0, mem_bus.mem_req}, {31'b0, m_busy});
        if (m_busy) check("mem_addr", mem_bus.mem_addr, m_addr);
        check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("if_pc", if_pc, m_ipc);
            check("if_instruction", if_instruction, m_instr);
        end
        if (if_valid && if_pc == 32'h0) saw_wrap_pc = 1;
        if (saw_wrap_pc && mem_bus.mem_req && mem_bus.mem_addr == 32'h0) saw_wrap_addr = 1;
    endtask

    task automatic step(input bit force_br, input logic [31:0] force_addr);
        drive_inputs(force_br, force_addr);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_phase(input int cycles, input int hz, input int br, input int lmin, input int lmax);
        set_knobs(hz, br, lmin, lmax);
        for (int i = 0; i < cycles; i++) step(1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, {31'b0, mem_bus.mem_req}, 32'h0);
        check({tag, "_mem_addr"}, mem_bus.mem_addr, 32'h0);
        check({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
        check({tag, "_if_pc"}, if_pc, 32'h0);
        check({tag, "_if_instruction"}, if_instruction, 32'h0);
    endtask

    task automatic mid_request_reset();
        int guard;
        set_knobs(0, 0, 3, 3);
        guard = 0;
        while (!(m_busy && lat_left > 0) && guard < 50) begin
            step(1'b0, 32'h0);
            guard++;
        end
        check("busy_before_reset", {31'b0, mem_bus.mem_req}, 32'h1);
        #2;
        rst = 1'b0;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst               = 1'b0;
        hazard_stall      = 1'b0;
        branch_taken      = 1'b0;
        branch_address    = 32'h0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        saw_wrap_pc       = 0;
        saw_wrap_addr     = 0;
        set_knobs(0, 0, 0, 0);
        model_reset();

        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b1;

        run_phase(12, 0, 0, 0, 0);
        run_phase(30, 0, 0, 3, 3);
        run_phase(60, 50, 0, 0, 2);
        run_phase(80, 0, 20, 0, 3);

        mid_request_reset();

        // Redirect to the top of the address space and follow the wrap to zero.
        set_knobs(0, 0, 0, 0);
        saw_wrap_pc   = 0;
        saw_wrap_addr = 0;
        step(1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
        check("wrap_if_pc_zero", {31'b0, saw_wrap_pc}, 32'h1);
        check("wrap_mem_addr_zero", {31'b0, saw_wrap_addr}, 32'h1);

        run_phase(3000, 30, 10, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch for the IF stage against a variable-latency instruction memory using a req/ready handshake.
- Owns the fetch PC and a one-entry output register that holds the fetched instruction and its PC+4.
- Applies downstream hazard stalls, and applies branch redirects from EXE as a flush plus PC reload.
- Squashes any fetch still in flight when a branch arrives.

Parameters:
- BIT_NUMBER, 32, width of PC, addresses and instruction words
- PC_STEP, 4, sequential PC increment in bytes
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- hazard_stall  input  1  downstream cannot accept; hold output register
- branch_taken  input  1  single-cycle redirect pulse
- branch_address  input  BIT_NUMBER  redirect target
- mem_ready  input  1  memory completes the current request this cycle
- mem_rdata  input  BIT_NUMBER  instruction word, valid when mem_ready=1
- mem_req  output  1  fetch request, registered (Moore)
- mem_addr  output  BIT_NUMBER  fetch address, stable while mem_req=1
- if_valid  output  1  output register holds a live instruction
- if_pc  output  BIT_NUMBER  fetched address + PC_STEP
- if_instruction  output  BIT_NUMBER  fetched instruction word

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instruction=0.
- Definitions:
  - completion = mem_req && mem_ready, sampled at the rising edge.
  - consume = if_valid && !hazard_stall.
  - slot_free = !if_valid || !hazard_stall.
- States:
  - IDLE: mem_req=0. Go to REQ when slot_free && !branch_taken.
  - REQ: mem_req=1, mem_addr=fetch_pc.
    - On completion without branch: load output register (if_valid=1, if_instruction=mem_rdata, if_pc=fetch_pc+PC_STEP), fetch_pc+=PC_STEP, go to IDLE.
  - SQUASH: mem_req=1 at the old address, held until completion. Data is discarded. Then go to IDLE.
- mem_req rule: once asserted, mem_req is never withdrawn before completion, even on branch. Memory may assert ready in the same cycle req rises (zero-wait).
- Throughput: peak one instruction per 2 cycles with zero-wait memory, because IDLE is a mandatory bubble.
- Invariant: a request is issued only while the output slot is free. A completion therefore never overwrites an unconsumed instruction.
- Output register:
  - Held unchanged while if_valid && hazard_stall.
  - Cleared (if_valid=0) on consume with no completion in the same cycle.
- branch_taken (highest priority, overrides hazard_stall):
  - Next cycle: if_valid=0, fetch_pc=branch_address (used unmodified).
  - In IDLE: stay in IDLE; request the target from the following cycle if slot_free.
  - In REQ with completion in the same cycle: discard the data, go to IDLE.
  - In REQ without completion: go to SQUASH.
  - In SQUASH: overwrite fetch_pc with the new target; stay in SQUASH.
- Wrap-around: fetch_pc + PC_STEP is modulo 2^BIT_NUMBER; no overflow flag.
- Reset mid-request: mem_req drops immediately (asynchronous). Any memory response arriving afterwards is ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding localparams: IDLE=2'd0, REQ=2'd1, SQUASH=2'd2;
  - default PC_STEP and RESET_PC constants.
- One sub-module, fetch_out_reg: one-entry holding register with load / hold / clear controls and an asynchronous active-low reset.
- The FSM and fetch_pc stay in fetch_controller.

Test Plan:
- Reset release, mem_ready tied 1, hazard_stall=0 -> mem_addr sequence 0,4,8,12 on alternate cycles; if_pc 4,8,12,16; if_valid toggles 1/0.
- mem_ready delayed 3 cycles -> mem_req and mem_addr=0 held stable for 4 cycles; if_instruction=mem_rdata captured on the ready edge only.
- hazard_stall=1 for 5 cycles with if_valid=1 -> if_instruction/if_pc frozen and mem_req=0 throughout; next request issues in the cycle after stall drops.
- branch_taken with branch_address=0x100 while REQ is outstanding (ready 2 cycles later) -> SQUASH; old data dropped, if_valid stays 0; next mem_addr=0x100; if_pc later 0x104.
- branch_taken and completion in the same cycle -> if_valid=0 next cycle; next mem_addr=branch_address; the completed word never appears.
- rst pulsed low mid-REQ -> mem_req=0 and if_valid=0 asynchronously; after release, first mem_addr=RESET_PC. Also cover fetch_pc=0xFFFFFFFC wrapping to 0.
